// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: memory opcodes, responder FSM states, port ids
// and the address range helper.
package mips32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WCNT_W = 4;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Opcode decode shared with the core's MEM stage.
  function automatic logic op_is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Range check uses every address bit, not just the array index.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                         input int unsigned     depth);
    return addr < XLEN'(depth);
  endfunction

endpackage

// File: rtl/mips32_mem_array.sv
// Single-port synchronous word RAM: one read or one write per clock.
// Contents are deliberately not reset.
module mips32_mem_array
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory responder for the MIPS32 core: arbitrates fetch and data requests
// onto one RAM with configurable wait states and registered responses.
module mips32_mem_responder
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid_i,
  output logic            i_req_ready_o,
  input  logic [XLEN-1:0] i_req_addr_i,
  output logic            i_rsp_valid_o,
  output logic [XLEN-1:0] i_rsp_data_o,
  output logic            i_rsp_err_o,
  input  logic            d_req_valid_i,
  output logic            d_req_ready_o,
  input  logic            d_req_we_i,
  input  logic [XLEN-1:0] d_req_addr_i,
  input  logic [XLEN-1:0] d_req_wdata_i,
  output logic            d_rsp_valid_o,
  output logic [XLEN-1:0] d_rsp_rdata_o,
  output logic            d_rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [WCNT_W-1:0] WCNT_INIT =
    WCNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              port_q, we_q, oor_q;
  logic [AW-1:0]     idx_q;
  logic [XLEN-1:0]   wdata_q;

  logic            req_ok, d_acc, i_acc, acc;
  logic            req_port, req_we, req_oor;
  logic [XLEN-1:0] req_addr;
  logic            from_wait, mem_go, mem_en, mem_we, mem_oor;
  logic [AW-1:0]   mem_idx;
  logic [XLEN-1:0] mem_wdata, mem_rdata, rsp_data;
  logic            rsp_i, rsp_d;

  logic            i_rsp_valid_q, i_rsp_err_q, d_rsp_valid_q, d_rsp_err_q;
  logic [XLEN-1:0] i_rsp_data_q, d_rsp_data_q;

  // Data port has fixed priority: it carries the older instruction.
  assign req_ok        = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign d_req_ready_o = req_ok;
  assign i_req_ready_o = req_ok && !d_req_valid_i;
  assign d_acc         = req_ok && d_req_valid_i;
  assign i_acc         = req_ok && i_req_valid_i && !d_req_valid_i;
  assign acc           = d_acc || i_acc;

  assign req_port = d_acc ? PORT_D : PORT_I;
  assign req_addr = d_acc ? d_req_addr_i : i_req_addr_i;
  assign req_we   = d_acc && d_req_we_i;
  assign req_oor  = !addr_in_range(req_addr, DEPTH);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_RESP;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      default: begin
        if (acc) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // RAM is touched only on the edge that enters RESP; with no wait states
  // that is the acceptance edge itself, so the live request is used.
  assign from_wait = (state_q == ST_WAIT);
  assign mem_go    = !rst && ((from_wait && wcnt_q == '0) || (acc && WAIT_STATES == 0));
  assign mem_idx   = from_wait ? idx_q   : req_addr[AW-1:0];
  assign mem_we    = from_wait ? we_q    : req_we;
  assign mem_oor   = from_wait ? oor_q   : req_oor;
  assign mem_wdata = from_wait ? wdata_q : d_req_wdata_i;
  assign mem_en    = mem_go && !mem_oor;

  mips32_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      port_q  <= PORT_I;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (acc) begin
        port_q  <= req_port;
        we_q    <= req_we;
        oor_q   <= req_oor;
        idx_q   <= req_addr[AW-1:0];
        wdata_q <= d_req_wdata_i;
      end
    end
  end

  // Response registers: only the selected port pulses, the other stays 0.
  assign rsp_data = (we_q || oor_q) ? '0 : mem_rdata;
  assign rsp_i    = (state_q == ST_RESP) && (port_q == PORT_I);
  assign rsp_d    = (state_q == ST_RESP) && (port_q == PORT_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      i_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
      d_rsp_err_q   <= 1'b0;
    end else begin
      i_rsp_valid_q <= rsp_i;
      i_rsp_data_q  <= rsp_i ? rsp_data : '0;
      i_rsp_err_q   <= rsp_i && oor_q;
      d_rsp_valid_q <= rsp_d;
      d_rsp_data_q  <= rsp_d ? rsp_data : '0;
      d_rsp_err_q   <= rsp_d && oor_q;
    end
  end

  assign i_rsp_valid_o = i_rsp_valid_q;
  assign i_rsp_data_o  = i_rsp_data_q;
  assign i_rsp_err_o   = i_rsp_err_q;
  assign d_rsp_valid_o = d_rsp_valid_q;
  assign d_rsp_rdata_o = d_rsp_data_q;
  assign d_rsp_err_o   = d_rsp_err_q;

endmodule
